// File: rtl/beep_driver_pkg.sv
// Shared definitions for the beep driver: FSM state encoding and counter sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package beep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } beep_state_t;

    // Width of a down-counter that must hold the larger of the two phase lengths
    function automatic int cnt_width(input int on_cycles, input int off_cycles);
        int longest;
        longest = (on_cycles > off_cycles) ? on_cycles : off_cycles;
        return (longest < 1) ? 1 : $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/beep_driver_tone_gen.sv
// Tone generator: square wave that toggles every TONE_DIV cycles while enabled.
// Latency: output registered; restart makes it high on the following cycle.
// Backpressure: none; forced low whenever en is low.
module tone_gen #(
    parameter int TONE_DIV = 25000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tone
);

    localparam int DW = (TONE_DIV < 2) ? 1 : $clog2(TONE_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(TONE_DIV - 1);

    logic [DW-1:0] div_cnt;

    // Divider plus toggle flop; restart aligns the wave to start high on each beep
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            tone    <= 1'b0;
            div_cnt <= '0;
        end else if (restart) begin
            tone    <= 1'b1;
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            tone    <= ~tone;
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/beep_driver.sv
// Beep driver: turns one-cycle trig pulses into fixed ON pulses with a fixed OFF gap; tone via BEEP_DRIVER_TONE_EN.
// Latency: out rises exactly 1 cycle after trig when idle; all outputs registered.
// Backpressure: trigs during a beep queue up to MAX_PEND; beyond that they are dropped and flagged on dropped.
module beep_driver #(
    parameter int ON_CYCLES  = 50000000,
    parameter int OFF_CYCLES = 25000000,
    parameter int MAX_PEND   = 3,
    parameter int TONE_DIV   = 25000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            trig,
    output logic                            out,
    output logic                            busy,
    output logic [$clog2(MAX_PEND+1)-1:0]   pending,
    output logic                            dropped
);

    import beep_pkg::*;

    localparam int CW = cnt_width(ON_CYCLES, OFF_CYCLES);
    localparam int PW = $clog2(MAX_PEND + 1);

    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);

    beep_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [PW-1:0] pend_n, pend_sum;
    logic          q_inc, drop_n;

    // Next-state decode; a trig on the final OFF cycle is folded into the queue
    // before the dequeue decision so it can start the next beep without an IDLE gap.
    // A full queue drops the request even on the final OFF cycle.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        pend_n   = pending;
        q_inc    = trig && (state != ST_IDLE) && (pending != PEND_MAX);
        drop_n   = trig && (state != ST_IDLE) && (pending == PEND_MAX);
        pend_sum = pending + PW'(q_inc);
        case (state)
            ST_IDLE: begin
                if (trig) begin
                    state_n = ST_ON;
                    cnt_n   = ON_LOAD;
                end
            end
            ST_ON: begin
                pend_n = pend_sum;
                if (cnt == '0) begin
                    state_n = ST_OFF;
                    cnt_n   = OFF_LOAD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_OFF: begin
                if (cnt == '0) begin
                    if (pend_sum != '0) begin
                        state_n = ST_ON;
                        cnt_n   = ON_LOAD;
                        pend_n  = pend_sum - PW'(1);
                    end else begin
                        state_n = ST_IDLE;
                        pend_n  = '0;
                    end
                end else begin
                    cnt_n  = cnt - CW'(1);
                    pend_n = pend_sum;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                pend_n  = '0;
            end
        endcase
    end

    // State, counter, queue depth and status flags, all registered together
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pending <= '0;
            busy    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pending <= pend_n;
            busy    <= (state_n != ST_IDLE);
            dropped <= drop_n;
        end
    end

`ifdef BEEP_DRIVER_TONE_EN
    logic tone_en, tone_restart;
    assign tone_en      = (state_n == ST_ON);
    assign tone_restart = (state_n == ST_ON) && (state != ST_ON);

    tone_gen #(
        .TONE_DIV (TONE_DIV)
    ) u_tone (
        .clk     (clk),
        .reset   (reset),
        .en      (tone_en),
        .restart (tone_restart),
        .tone    (out)
    );
`else
    // Steady drive level for the whole ON phase
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= 1'b0;
        end else begin
            out <= (state_n == ST_ON);
        end
    end
`endif

endmodule

// File: doc/beep_driver.md
Name: beep_driver

Overview:
- Output-side counterpart to the button pulse conditioner.
- Accepts single-cycle event pulses from stopwatch control logic (start/stop/lap/alarm) and turns each into a clean, human-perceivable output pulse of fixed length with a guaranteed gap between pulses.
- Drives a buzzer or LED pin.
- Events arriving while a pulse is in progress are counted and replayed in order, up to a saturating limit.

Parameters:
- ON_CYCLES, 50000000, clock cycles the output is held active per beep (≥1)
- OFF_CYCLES, 25000000, minimum inactive gap after each beep before the next may start (≥1)
- MAX_PEND, 3, maximum queued beeps beyond the one in progress (≥1); extra requests are dropped
- TONE_DIV, 25000, half-period in cycles of tone modulation (used only with TONE_EN)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- trig  input  1  one-cycle beep request
- out  output  1  buzzer/LED drive, active high
- busy  output  1  high in ON or OFF phase
- pending  output  $clog2(MAX_PEND+1)  queued beeps not yet started
- dropped  output  1  one-cycle pulse when a trig is discarded because the queue is full

Behaviour:
- Reset: already decided, one clock `clk`; reset is synchronous and active-high on `reset`.
  - When reset is sampled high: state=IDLE, out=0, busy=0, pending=0, dropped=0, all counters 0.
  - Reset overrides trig in the same cycle.
- States: IDLE, ON, OFF. Down-counter cnt, width $clog2(max(ON_CYCLES,OFF_CYCLES)+1).
- IDLE:
  - trig=1 → ON, cnt=ON_CYCLES-1, out=1 from the next cycle.
  - Latency is exactly 1 cycle from trig to out rising.
- ON:
  - out=1. cnt decrements each cycle.
  - At cnt==0 → OFF, cnt=OFF_CYCLES-1.
  - out is high for exactly ON_CYCLES cycles.
- OFF:
  - out=0. cnt decrements.
  - At cnt==0: if pending>0 (after applying this cycle's trig) → ON with pending-1; else → IDLE.
  - Gap is exactly OFF_CYCLES cycles.
- trig in ON or OFF:
  - pending increments if pending<MAX_PEND.
  - Otherwise the request is discarded and dropped=1 the next cycle.
- trig on the final OFF cycle with pending=0: pending goes to 0 and state goes straight to ON; the request is consumed, not queued.
- trig on the final OFF cycle with pending>0: increment and decrement cancel, so pending is unchanged.
- busy = (state != IDLE), registered with the state.
- All outputs are registered; no combinational path from trig to out.
- trig held high for k cycles counts as k requests; upstream guarantees single-cycle pulses.

Optional Feature:
- Macro BEEP_DRIVER_TONE_EN.
- Defined:
  - During ON, out = tone square wave: a toggle flop that inverts every TONE_DIV cycles.
  - The toggle flop restarts high on each ON entry and is forced 0 outside ON.
  - Suits passive piezo drive.
- Undefined: out is a steady level during ON. TONE_DIV is ignored and no tone logic is synthesised.

Decomposition:
- Package beep_pkg holds:
  - state encoding constants (IDLE=2'd0, ON=2'd1, OFF=2'd2)
  - counter-width helper function
- Natural sub-module: tone_gen (divider plus toggle flop, with enable/restart input), instantiated only under BEEP_DRIVER_TONE_EN.
- Bench parameters: ON_CYCLES=4, OFF_CYCLES=3, MAX_PEND=2.

Test Plan:
- Single trig at cycle 10 → out=1 for cycles 11–14, 0 from 15; busy=1 for cycles 11–17; IDLE at 18; pending stays 0.
- 5 trigs on consecutive cycles 10–14 → pending 1,2,2,2; dropped pulses at cycles 14 and 15; exactly 3 beeps, rising at 11, 18, 25.
- trig on the last OFF cycle (17) after a single beep → out rises at 18 with no IDLE cycle; pending remains 0.
- reset asserted at cycle 12 mid-ON with pending=1 → at cycle 13 out=0, busy=0, pending=0; no further beeps without new trig.
- trig coincident with the queued-beep start at cycle 17 (pending=1) → pending stays 1; third beep rises at 25.
- BEEP_DRIVER_TONE_EN, TONE_DIV=1, ON_CYCLES=4 → during ON, out reads 1,0,1,0; out=0 in OFF and IDLE.
